// File: rtl/drum_lod_pipe.sv
// Two-stage leading-one detector and DRUM window extractor with valid/ready flow control.
// Stage 1 finds the leading one; stage 2 cuts the K-bit window and the rescale shift.
module drum_lod_pipe #(
    parameter int WIDTH = 16,
    parameter int K     = 6,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] out_pos,
    output logic             out_zero,
    output logic [K-1:0]     out_seg,
    output logic [POS_W-1:0] out_shift
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic [POS_W-1:0] s1_pos_q, s1_pos_d;
    logic             s1_zero_q, s1_zero_d;

    logic             s2_valid_q, s2_valid_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             zero_q, zero_d;
    logic [K-1:0]     seg_q, seg_d;
    logic [POS_W-1:0] shift_q, shift_d;

    logic             s1_adv, s2_adv;
    logic [POS_W-1:0] lod_pos;
    logic             lod_zero;
    logic [K-1:0]     win_seg;
    logic [POS_W-1:0] win_shift;
    logic             force_lsb;
    int               p_int;
    int               sh;

    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv && !rst;

    assign out_valid = s2_valid_q;
    assign out_pos   = pos_q;
    assign out_zero  = zero_q;
    assign out_seg   = seg_q;
    assign out_shift = shift_q;

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        lod_pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_data[i]) begin
                lod_pos = POS_W'(i);
            end
        end
        lod_zero = (in_data == '0);
    end

    // Window selection uses constant bit indices per shift value so every select stays in range.
    always_comb begin
        p_int     = int'(s1_pos_q);
        sh        = 0;
        force_lsb = 1'b0;
        if (!s1_zero_q && p_int >= K) begin
            sh        = p_int - K + 1;
            force_lsb = 1'b1;
        end
        win_seg = '0;
        for (int j = 0; j < K; j++) begin
            for (int s = 0; s <= WIDTH - K; s++) begin
                if (sh == s) begin
                    win_seg[j] = s1_data_q[j+s];
                end
            end
        end
        if (force_lsb) begin
            win_seg[0] = 1'b1;
        end
        win_shift = POS_W'(sh);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_pos_d   = s1_pos_q;
        s1_zero_d  = s1_zero_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_pos_d  = lod_pos;
                s1_zero_d = lod_zero;
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        pos_d      = pos_q;
        zero_d     = zero_q;
        seg_d      = seg_q;
        shift_d    = shift_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                pos_d   = s1_pos_q;
                zero_d  = s1_zero_q;
                seg_d   = s1_zero_q ? '0 : win_seg;
                shift_d = s1_zero_q ? '0 : win_shift;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_pos_q   <= '0;
            s1_zero_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            pos_q      <= '0;
            zero_q     <= 1'b0;
            seg_q      <= '0;
            shift_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_pos_q   <= s1_pos_d;
            s1_zero_q  <= s1_zero_d;
            s2_valid_q <= s2_valid_d;
            pos_q      <= pos_d;
            zero_q     <= zero_d;
            seg_q      <= seg_d;
            shift_q    <= shift_d;
        end
    end

endmodule

// File: tb/tb_drum_lod_pipe.sv
// Directed-vector bench for drum_lod_pipe (WIDTH=16, K=6).
// Each scenario task drives its own stimulus and compares against hand-computed values.
module tb_drum_lod_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_pos;
    logic        out_zero;
    logic [5:0]  out_seg;
    logic [3:0]  out_shift;

    int checks   = 0;
    int failures = 0;

    localparam logic [15:0] VEC_DATA  [8] = '{16'h0001, 16'h002D, 16'hB3C5, 16'h0000,
                                              16'h8000, 16'h0041, 16'h003F, 16'h0FFE};
    localparam logic [3:0]  VEC_POS   [8] = '{4'd0, 4'd5, 4'd15, 4'd0, 4'd15, 4'd6, 4'd5, 4'd11};
    localparam logic        VEC_ZERO  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [5:0]  VEC_SEG   [8] = '{6'b000001, 6'b101101, 6'b101101, 6'b000000,
                                              6'b100001, 6'b100001, 6'b111111, 6'b111111};
    localparam logic [3:0]  VEC_SHIFT [8] = '{4'd0, 4'd0, 4'd10, 4'd0, 4'd10, 4'd1, 4'd0, 4'd6};
    localparam logic [3:0]  STREAM_POS [16] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3,
                                                4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};

    drum_lod_pipe #(.WIDTH(16), .K(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pos   (out_pos),
        .out_zero  (out_zero),
        .out_seg   (out_seg),
        .out_shift (out_shift)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        #3;
        checks++;
        if ({out_valid, out_pos, out_zero, out_seg, out_shift} !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%h exp=0", {out_valid, out_pos, out_zero, out_seg, out_shift});
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset_out_valid got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_vectors;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = VEC_DATA[i];
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL vec%0d_in_ready got=%b exp=1", i, in_ready);
            end
            tick();
            in_valid = 1'b0;
            in_data  = 16'hFFFF;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL vec%0d_early_valid got=%b exp=0", i, out_valid);
            end
            tick();
            checks++;
            if ({out_valid, out_pos, out_zero, out_seg, out_shift} !==
                {1'b1, VEC_POS[i], VEC_ZERO[i], VEC_SEG[i], VEC_SHIFT[i]}) begin
                failures++;
                $display("[TB] FAIL vec%0d_fields data=%h got v=%b pos=%0d z=%b seg=%b sh=%0d exp v=1 pos=%0d z=%b seg=%b sh=%0d",
                         i, VEC_DATA[i], out_valid, out_pos, out_zero, out_seg, out_shift,
                         VEC_POS[i], VEC_ZERO[i], VEC_SEG[i], VEC_SHIFT[i]);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL vec%0d_drain got=%b exp=0", i, out_valid);
            end
        end
    endtask

    task automatic test_one_hot;
        logic [5:0] exp_seg;
        logic [3:0] exp_shift;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            // Below K the window is the raw low bits; from K upward it is 100000 with LSB forced.
            exp_seg   = (i < 6) ? 6'(1 << i) : 6'b100001;
            exp_shift = (i < 6) ? 4'd0 : 4'(i - 5);
            in_valid  = 1'b1;
            in_data   = 16'(1 << i);
            tick();
            in_valid  = 1'b0;
            tick();
            checks++;
            if ({out_valid, out_pos, out_zero, out_seg, out_shift} !==
                {1'b1, 4'(i), 1'b0, exp_seg, exp_shift}) begin
                failures++;
                $display("[TB] FAIL onehot%0d got v=%b pos=%0d z=%b seg=%b sh=%0d exp v=1 pos=%0d z=0 seg=%b sh=%0d",
                         i, out_valid, out_pos, out_zero, out_seg, out_shift, i, exp_seg, exp_shift);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        bit saw_full = 1'b0;
        logic [15:0] ev;
        while (recv < 16 && cyc < 100) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (sent < 16);
            in_data   = 16'(sent + 1);
            #1;
            if (in_valid && !in_ready) saw_full = 1'b1;
            if (out_valid) begin
                ev = 16'(recv + 1);
                checks++;
                if ({out_pos, out_zero, out_seg, out_shift} !== {STREAM_POS[recv], 1'b0, ev[5:0], 4'd0}) begin
                    failures++;
                    $display("[TB] FAIL stream_item%0d cyc=%0d got pos=%0d z=%b seg=%b sh=%0d exp pos=%0d z=0 seg=%b sh=0",
                             recv, cyc, out_pos, out_zero, out_seg, out_shift, STREAM_POS[recv], ev[5:0]);
                end
                if (out_ready) recv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (recv !== 16) begin
            failures++;
            $display("[TB] FAIL stream_count got=%0d exp=16", recv);
        end
        checks++;
        if (cyc !== 21) begin
            failures++;
            $display("[TB] FAIL stream_cycles got=%0d exp=21", cyc);
        end
        checks++;
        if (saw_full !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stream_backpressure got=%b exp=1", saw_full);
        end
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stream_extra_item got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0100;
        tick();
        in_data   = 16'h0200;
        tick();
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midrst_inflight got=%b exp=1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_pos, out_zero, out_seg, out_shift, in_ready} !== 17'h0) begin
            failures++;
            $display("[TB] FAIL midrst_async_clear got=%h exp=0",
                     {out_valid, out_pos, out_zero, out_seg, out_shift, in_ready});
        end
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0123;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midrst_in_ready got=%b exp=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_stale got=%b exp=0", out_valid);
        end
        tick();
        checks++;
        if ({out_valid, out_pos, out_zero, out_seg, out_shift} !== {1'b1, 4'd8, 1'b0, 6'b100101, 4'd3}) begin
            failures++;
            $display("[TB] FAIL midrst_result got v=%b pos=%0d z=%b seg=%b sh=%0d exp v=1 pos=8 z=0 seg=100101 sh=3",
                     out_valid, out_pos, out_zero, out_seg, out_shift);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_drain got=%b exp=0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_one_hot();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
